// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register between decode and execute.
// It carries a control bundle and a datapath payload, with a valid/ready
// handshake, a memory-hit freeze, flush support and a saturating count of
// entries discarded by flush.
// Optional feature macro: PIPE_STAGE_SKID_EN. When defined, the stage holds
// up to two entries and in_ready comes from a register. When undefined, the
// stage holds one entry and in_ready is derived combinationally.
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 70,
  parameter int CTRL_W    = 12,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hit,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     flush_drops
);

  // Head entry. This is the entry currently presented on out_*.
  logic [CTRL_W-1:0]    headCtrl_q, headCtrl_d;
  logic [PAYLOAD_W-1:0] headPayload_q, headPayload_d;

  // Number of entries held, plus the saturating flush-drop counter.
  logic [1:0]           count_q, count_d;
  logic [CNT_W-1:0]     flushDrops_q, flushDrops_d;

  // Handshake qualifiers. A frozen stage (hit=0) or a flush blocks both sides.
  logic                 acceptEn;
  logic                 releaseEn;
  logic                 headValid;
  logic [CNT_W:0]       dropSum;

`ifdef PIPE_STAGE_SKID_EN
  // Second entry, used only while downstream stalls with the head occupied.
  logic [CTRL_W-1:0]    skidCtrl_q, skidCtrl_d;
  logic [PAYLOAD_W-1:0] skidPayload_q, skidPayload_d;
  // Registered "room available" flag. This keeps out_ready off the
  // in_ready path.
  logic                 space_q;
`endif

  assign headValid = (count_q != 2'd0);
  assign out_valid = headValid;
  assign occupancy = count_q;
  assign flush_drops = flush_drops_w();
  assign out_payload = headPayload_q;

  function automatic logic [CNT_W-1:0] flush_drops_w();
    return flushDrops_q;
  endfunction

  // Mask control while no entry is presented, so a bubble never writes
  // registers or memory and never branches.
  always_comb begin
    out_ctrl = '0;
    if (headValid) begin
      out_ctrl = headCtrl_q;
    end
  end

  // Ready toward upstream. It is held low during reset and while the stage is frozen.
  always_comb begin
`ifdef PIPE_STAGE_SKID_EN
    in_ready = !rst && hit && space_q;
`else
    in_ready = !rst && hit && (!headValid || out_ready);
`endif
  end

  assign acceptEn  = in_valid && in_ready && hit && !flush;
  assign releaseEn = headValid && out_ready && hit && !flush;

  // Saturating add of the pre-flush occupancy into the drop counter.
  always_comb begin
    dropSum      = {1'b0, flushDrops_q} + {{(CNT_W-1){1'b0}}, count_q};
    flushDrops_d = flushDrops_q;
    if (flush) begin
      if (dropSum[CNT_W]) begin
        flushDrops_d = '1;
      end else begin
        flushDrops_d = dropSum[CNT_W-1:0];
      end
    end
  end

  // Next-state for the entry storage and occupancy. A flush empties the
  // stage. Otherwise, accepts and releases move entries in order.
  always_comb begin
    count_d       = count_q;
    headCtrl_d    = headCtrl_q;
    headPayload_d = headPayload_q;
`ifdef PIPE_STAGE_SKID_EN
    skidCtrl_d    = skidCtrl_q;
    skidPayload_d = skidPayload_q;
`endif
    if (flush) begin
      count_d = 2'd0;
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      case (count_q)
        2'd0: begin
          if (acceptEn) begin
            headCtrl_d    = in_ctrl;
            headPayload_d = in_payload;
            count_d       = 2'd1;
          end
        end
        2'd1: begin
          if (acceptEn && releaseEn) begin
            headCtrl_d    = in_ctrl;
            headPayload_d = in_payload;
          end else if (acceptEn) begin
            skidCtrl_d    = in_ctrl;
            skidPayload_d = in_payload;
            count_d       = 2'd2;
          end else if (releaseEn) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (releaseEn) begin
            headCtrl_d    = skidCtrl_q;
            headPayload_d = skidPayload_q;
            if (acceptEn) begin
              skidCtrl_d    = in_ctrl;
              skidPayload_d = in_payload;
            end else begin
              count_d = 2'd1;
            end
          end
        end
        default: begin
          count_d = 2'd0;
        end
      endcase
`else
      if (acceptEn) begin
        headCtrl_d    = in_ctrl;
        headPayload_d = in_payload;
        count_d       = 2'd1;
      end else if (releaseEn) begin
        count_d = 2'd0;
      end
`endif
    end
  end

  // State registers. Reset overrides hit and flush and clears everything,
  // including the drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= 2'd0;
      headCtrl_q    <= '0;
      headPayload_q <= '0;
      flushDrops_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skidCtrl_q    <= '0;
      skidPayload_q <= '0;
      space_q       <= 1'b1;
`endif
    end else begin
      count_q       <= count_d;
      headCtrl_q    <= headCtrl_d;
      headPayload_q <= headPayload_d;
      flushDrops_q  <= flushDrops_d;
`ifdef PIPE_STAGE_SKID_EN
      skidCtrl_q    <= skidCtrl_d;
      skidPayload_q <= skidPayload_d;
      space_q       <= (count_d != 2'd2);
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. It exercises whichever buffering
// mode is built (PIPE_STAGE_SKID_EN defined or not).
module tb_pipe_stage_reg;

  localparam int PAYLOAD_W = 70;
  localparam int CTRL_W    = 12;
  localparam int CNT_W     = 8;

  logic                 clk;
  logic                 rst;
  logic                 hit;
  logic                 flush;
  logic                 inValid;
  logic                 inReady;
  logic [CTRL_W-1:0]    inCtrl;
  logic [PAYLOAD_W-1:0] inPayload;
  logic                 outValid;
  logic                 outReady;
  logic [CTRL_W-1:0]    outCtrl;
  logic [PAYLOAD_W-1:0] outPayload;
  logic [1:0]           occupancy;
  logic [CNT_W-1:0]     flushDrops;

  int compareCount;
  int failCount;
  int expDrops;

  pipe_stage_reg #(
    .PAYLOAD_W(PAYLOAD_W),
    .CTRL_W(CTRL_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hit(hit),
    .flush(flush),
    .in_valid(inValid),
    .in_ready(inReady),
    .in_ctrl(inCtrl),
    .in_payload(inPayload),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_ctrl(outCtrl),
    .out_payload(outPayload),
    .occupancy(occupancy),
    .flush_drops(flushDrops)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic rstV, input logic hitV, input logic flushV,
                               input logic validV, input logic [CTRL_W-1:0] ctrlV,
                               input logic [PAYLOAD_W-1:0] payloadV, input logic outReadyV);
    rst       = rstV;
    hit       = hitV;
    flush     = flushV;
    inValid   = validV;
    inCtrl    = ctrlV;
    inPayload = payloadV;
    outReady  = outReadyV;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;

    // Reset with an upstream offer pending.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'h3C3, 70'h55, 1'b0);
    tick();
    tick();
    checkOutput("rst_occupancy", occupancy, 2'd0);
    checkOutput("rst_out_valid", outValid, 1'b0);
    checkOutput("rst_out_ctrl", outCtrl, 12'h0);
    checkOutput("rst_out_payload", outPayload, 70'h0);
    checkOutput("rst_flush_drops", flushDrops, 8'd0);
    checkOutput("rst_in_ready", inReady, 1'b0);

    // The first entry after reset appears one cycle later.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF, 70'h1, 1'b1);
    #1;
    checkOutput("first_in_ready", inReady, 1'b1);
    checkOutput("first_ctrl_before", outCtrl, 12'h0);
    tick();
    checkOutput("first_out_valid", outValid, 1'b1);
    checkOutput("first_out_ctrl", outCtrl, 12'hFFF);
    checkOutput("first_out_payload", outPayload, 70'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 70'h0, 1'b1);
    tick();
    checkOutput("bubble_out_valid", outValid, 1'b0);
    checkOutput("bubble_out_ctrl", outCtrl, 12'h0);
    checkOutput("bubble_payload_hold", outPayload, 70'h1);

    // Stream payloads 0 through 7 back to back.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, CTRL_W'(i + 1), PAYLOAD_W'(i), 1'b1);
      tick();
      checkOutput($sformatf("stream_payload_%0d", i), outPayload, 128'(i));
      checkOutput($sformatf("stream_ctrl_%0d", i), outCtrl, 128'(i + 1));
      checkOutput($sformatf("stream_valid_%0d", i), outValid, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 70'h0, 1'b1);
    tick();
    checkOutput("stream_drain_valid", outValid, 1'b0);
    checkOutput("stream_drain_occ", occupancy, 2'd0);

    // Freeze with hit=0 while an entry is presented and downstream is ready.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h5A5, 70'hAA, 1'b0);
    tick();
    checkOutput("freeze_load_valid", outValid, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'h111, 70'hBB, 1'b1);
    #1;
    checkOutput("freeze_in_ready", inReady, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("freeze_payload_%0d", i), outPayload, 70'hAA);
      checkOutput($sformatf("freeze_ctrl_%0d", i), outCtrl, 12'h5A5);
      checkOutput($sformatf("freeze_valid_%0d", i), outValid, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 70'h0, 1'b1);
    tick();
    checkOutput("unfreeze_release_valid", outValid, 1'b0);
    checkOutput("unfreeze_release_occ", occupancy, 2'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Fill both slots while stalled. The third offer waits upstream.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h010, 70'h10, 1'b0);
    tick();
    checkOutput("skid_occ1", occupancy, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h011, 70'h11, 1'b0);
    tick();
    checkOutput("skid_occ2", occupancy, 2'd2);
    checkOutput("skid_full_in_ready", inReady, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h012, 70'h12, 1'b0);
    tick();
    checkOutput("skid_hold_occ", occupancy, 2'd2);
    checkOutput("skid_hold_head", outPayload, 70'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h012, 70'h12, 1'b1);
    tick();
    checkOutput("skid_drain_1", outPayload, 70'h11);
    checkOutput("skid_drain_1_occ", occupancy, 2'd1);
    tick();
    checkOutput("skid_drain_2", outPayload, 70'h12);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 70'h0, 1'b1);
    tick();
    checkOutput("skid_drain_empty", occupancy, 2'd0);

    // Flush a full stage while an entry is being offered.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h020, 70'h20, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h021, 70'h21, 1'b0);
    tick();
    checkOutput("preflush_occ", occupancy, 2'd2);
    expDrops = 2;
`else
    // Single-entry mode: in_ready tracks out_ready combinationally.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h030, 70'h30, 1'b0);
    tick();
    checkOutput("single_full_in_ready", inReady, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h031, 70'h31, 1'b1);
    #1;
    checkOutput("single_comb_in_ready", inReady, 1'b1);
    tick();
    checkOutput("single_replace_payload", outPayload, 70'h31);
    checkOutput("single_occ_bit1", occupancy, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h032, 70'h32, 1'b0);
    expDrops = 1;
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h7FF, 70'h22, 1'b1);
    tick();
    checkOutput("flush_occ", occupancy, 2'd0);
    checkOutput("flush_out_valid", outValid, 1'b0);
    checkOutput("flush_out_ctrl", outCtrl, 12'h0);
    checkOutput("flush_drops", flushDrops, 128'(expDrops));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 70'h0, 1'b1);
    tick();
    checkOutput("flush_offer_dropped", outValid, 1'b0);

    // Drive the drop counter into saturation with repeated single-entry flushes.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 70'h40, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h0, 70'h0, 1'b0);
      tick();
      expDrops = (expDrops + 1 > 255) ? 255 : expDrops + 1;
    end
    checkOutput("sat_drops", flushDrops, 128'(expDrops));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 70'h41, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h0, 70'h0, 1'b0);
    tick();
    checkOutput("sat_hold_255", flushDrops, 8'd255);
    checkOutput("flush_without_hit_occ", occupancy, 2'd0);

    // Reset overrides flush. An in-flight entry is lost and the drop count clears.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h002, 70'h50, 1'b0);
    tick();
    checkOutput("prereset_valid", outValid, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h003, 70'h51, 1'b1);
    tick();
    checkOutput("rst_override_occ", occupancy, 2'd0);
    checkOutput("rst_override_drops", flushDrops, 8'd0);
    checkOutput("rst_override_payload", outPayload, 70'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter PAYLOAD_W, default 70, width of the datapath payload (nextinst, readData1, readData2, signExtend at 16 bits each, plus rt and rd at 3 bits each).
REQ-002 SHALL provide parameter CTRL_W, default 12, width of the control bundle (regDst, ALUSrc, memtoReg, regWrite, memRead, memWrite, branch, ALUOp[1:0], opCode[2:0]).
REQ-003 SHALL provide parameter CNT_W, default 8, width of the flush-drop counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 hit  in  1  memory-hit qualifier; 0 freezes the stage.
REQ-007 flush  in  1  discard all stage contents.
REQ-008 in_valid  in  1  upstream offers an entry.
REQ-009 in_ready  out  1  stage accepts an entry this cycle.
REQ-010 in_ctrl  in  CTRL_W  control bundle.
REQ-011 in_payload  in  PAYLOAD_W  datapath bundle.
REQ-012 out_valid  out  1  stage presents an entry.
REQ-013 out_ready  in  1  downstream consumes the entry.
REQ-014 out_ctrl  out  CTRL_W  presented control bundle.
REQ-015 out_payload  out  PAYLOAD_W  presented datapath bundle.
REQ-016 occupancy  out  2  number of entries held (0..2).
REQ-017 flush_drops  out  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-018 SHALL accept an entry when in_valid && in_ready && hit && !flush, and release one when out_valid && out_ready && hit && !flush.
REQ-019 SHALL present an entry accepted into an empty stage on out_* in the next cycle (1-cycle latency).
REQ-020 SHALL deliver entries in acceptance order, never duplicating or dropping any except on flush.
REQ-021 SHALL drive out_ctrl to all zeros whenever out_valid=0, so a bubble never asserts regWrite, memWrite, memRead or branch; out_payload SHALL hold its last value.
REQ-022 With hit=0 and flush=0, SHALL hold all state and deassert in_ready; out_valid and out_* SHALL remain stable; out_ready SHALL be ignored.
REQ-023 With flush=1, SHALL set occupancy to 0 on the next edge regardless of hit, in_valid or out_ready; any simultaneous input offer SHALL be dropped and SHALL NOT be counted.
REQ-024 On flush, SHALL add the pre-flush occupancy to flush_drops, saturating at 2^CNT_W-1 without wrapping.
REQ-025 With a simultaneous accept and release, SHALL leave occupancy unchanged.

Reset
REQ-026 On a rising edge with rst=1, SHALL force occupancy=0, out_valid=0, out_ctrl=0, out_payload=0 and flush_drops=0.
REQ-027 While rst=1, in_ready SHALL be 0; the first accept SHALL be possible on the cycle after rst falls.
REQ-028 rst SHALL override hit and flush, and an in-flight entry SHALL be lost without incrementing flush_drops.

Configuration
REQ-029 The macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-030 With PIPE_STAGE_SKID_EN defined, the stage SHALL hold up to 2 entries, and in_ready SHALL be a registered signal equal to hit && occupancy<2; sustained throughput SHALL be 1 entry/cycle with no combinational out_ready-to-in_ready path.
REQ-031 Without PIPE_STAGE_SKID_EN, the stage SHALL hold at most 1 entry; occupancy[1] SHALL be tied to 0, and in_ready SHALL be hit && (!out_valid || out_ready), combinationally.

Verification
REQ-032 Reset then in_valid=1, in_ctrl=12'hFFF, in_payload=70'h1 and out_ready=1 -> out_valid=1 and out_ctrl=12'hFFF one cycle later; out_ctrl=0 before that.
REQ-033 Stream 8 entries (payload 0..7) with out_ready=1 -> out payloads 0..7 in order, 1 per cycle, in both modes.
REQ-034 SKID_EN, out_ready=0, offer 3 entries -> occupancy=2 and in_ready=0 after 2 accepts; third entry held upstream; releasing out_ready delivers all 3 in order.
REQ-035 Hold occupancy=2, pulse flush with in_valid=1 -> occupancy=0, out_valid=0, out_ctrl=0 and flush_drops=2 the next cycle; offered entry never appears.
REQ-036 hit=0 for 5 cycles with out_valid=1 and out_ready=1 -> out_* stable and no release; hit=1 -> release resumes; flush_drops at 255 plus a flush -> remains 255.
